// File: rtl/rf_pkg.sv
// Shared definitions for the register-file transfer sequencer: op codes,
// register indices and the sequencer state encoding.
package rf_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LDI = 2'b01,
    OP_SWP = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_F = 3'd4;
  localparam int REG_COUNT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_WR0,
    ST_WR1,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/rf_sel_decode.sv
// Register index to one-hot select decoder; vld flags indices that name
// an existing register.
module rf_sel_decode
  import rf_pkg::*;
(
  input  logic [2:0]           idx,
  output logic [REG_COUNT-1:0] sel,
  output logic                 vld
);

  always_comb begin
    sel = '0;
    vld = 1'b1;
    case (idx)
      REG_A:   sel = 5'b00001;
      REG_B:   sel = 5'b00010;
      REG_C:   sel = 5'b00100;
      REG_D:   sel = 5'b01000;
      REG_F:   sel = 5'b10000;
      default: vld = 1'b0;
    endcase
  end

endmodule

// File: rtl/rf_seq.sv
// Transfer sequencer: accepts one MOV/LDI/SWP/CLR request at a time and
// drives register-file selects, strobes and write data from registered outputs.
module rf_seq
  import rf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_dst,
  input  logic [2:0]       req_src,
  input  logic [WIDTH-1:0] req_imm,
  output logic             rf_as,
  output logic             rf_bs,
  output logic             rf_cs,
  output logic             rf_ds,
  output logic             rf_fs,
  output logic             rf_re,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_d,
  input  logic [WIDTH-1:0] rf_p,
  input  logic [WIDTH-1:0] rf_fo,
  output logic             done,
  output logic             err
);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [2:0]             dst_q, dst_d, src_q, src_d;
  logic [WIDTH-1:0]       imm_q, imm_d, t0_q, t0_d, t1_q, t1_d, wd_q, wd_d;
  logic [REG_COUNT-1:0]   sel_q, sel_d, dst_sel, src_sel;
  logic                   re_q, re_d, we_q, we_d, done_q, done_d, err_q, err_d;
  logic                   dst_vld, src_vld, accept, src_used;

  assign accept = (state_q == ST_IDLE) && req_valid;

  always_comb begin
    op_d  = op_q;
    dst_d = dst_q;
    src_d = src_q;
    imm_d = imm_q;
    if (accept) begin
      op_d  = op_e'(req_op);
      dst_d = req_dst;
      src_d = req_src;
      imm_d = req_imm;
    end
  end

  // The same decoders validate a fresh request and drive the active select.
  rf_sel_decode u_dst_dec (.idx(dst_d), .sel(dst_sel), .vld(dst_vld));
  rf_sel_decode u_src_dec (.idx(src_d), .sel(src_sel), .vld(src_vld));

  always_comb begin
    state_d  = state_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    src_used = (op_d == OP_MOV) || (op_d == OP_SWP);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!dst_vld || (src_used && !src_vld)) state_d = ST_FAIL;
          else if (src_used)                      state_d = ST_RD0;
          else                                    state_d = ST_WR0;
        end
      end
      ST_RD0: begin
        t0_d    = (src_q == REG_F) ? rf_fo : rf_p;
        state_d = (op_q == OP_SWP) ? ST_RD1 : ST_WR0;
      end
      ST_RD1: begin
        t1_d    = (dst_q == REG_F) ? rf_fo : rf_p;
        state_d = ST_WR0;
      end
      ST_WR0: begin
        if (op_q == OP_SWP) begin
          state_d = ST_WR1;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_WR1: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_FAIL: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    sel_d = '0;
    re_d  = 1'b0;
    we_d  = 1'b0;
    wd_d  = '0;
    case (state_d)
      ST_RD0: begin
        sel_d = src_sel;
        re_d  = 1'b1;
      end
      ST_RD1: begin
        sel_d = dst_sel;
        re_d  = 1'b1;
      end
      ST_WR0: begin
        sel_d = dst_sel;
        we_d  = 1'b1;
        case (op_d)
          OP_MOV, OP_SWP: wd_d = t0_d;
          OP_LDI:         wd_d = imm_d;
          default:        wd_d = '0;
        endcase
      end
      ST_WR1: begin
        sel_d = src_sel;
        we_d  = 1'b1;
        wd_d  = t1_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MOV;
      dst_q   <= '0;
      src_q   <= '0;
      imm_q   <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      sel_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      imm_q   <= imm_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      sel_q   <= sel_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rf_as     = sel_q[0];
  assign rf_bs     = sel_q[1];
  assign rf_cs     = sel_q[2];
  assign rf_ds     = sel_q[3];
  assign rf_fs     = sel_q[4];
  assign rf_re     = re_q;
  assign rf_we     = we_q;
  assign rf_d      = wd_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rf_seq.sv
// Bench for rf_seq: stub register file, transaction-level expected bus
// activity model, directed scenarios and a randomized request stream.
module tb_rf_seq;

  localparam int W = 8;

  typedef struct packed {
    logic [4:0] sel;
    logic       re;
    logic       we;
    logic [7:0] d;
    logic       done;
    logic       err;
    logic       ready;
  } bus_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [1:0]   req_op;
  logic [2:0]   req_dst, req_src;
  logic [W-1:0] req_imm;
  logic         rf_as, rf_bs, rf_cs, rf_ds, rf_fs, rf_re, rf_we, done, err;
  logic [W-1:0] rf_d, rf_p, rf_fo;
  logic [4:0]   sel_v;
  logic         stub_clr;
  logic [7:0]   stub [5];
  logic [7:0]   m [5];
  bus_t         q [$];
  int           checks = 0;
  int           failures = 0;

  rf_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dst(req_dst), .req_src(req_src), .req_imm(req_imm),
    .rf_as(rf_as), .rf_bs(rf_bs), .rf_cs(rf_cs), .rf_ds(rf_ds), .rf_fs(rf_fs),
    .rf_re(rf_re), .rf_we(rf_we), .rf_d(rf_d), .rf_p(rf_p), .rf_fo(rf_fo),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign sel_v = {rf_fs, rf_ds, rf_cs, rf_bs, rf_as};
  assign rf_fo = stub[4];

  // Stub register file; rf_p carries a poison pattern whenever A-D is not read.
  always_comb begin
    rf_p = 8'hEE;
    if (rf_re)
      for (int i = 0; i < 4; i++)
        if (sel_v[i]) rf_p = stub[i];
  end

  always @(posedge clk) begin
    if (stub_clr) begin
      for (int i = 0; i < 5; i++) stub[i] <= 8'h00;
    end else if (rf_we) begin
      for (int i = 0; i < 5; i++)
        if (sel_v[i]) stub[i] <= rf_d;
    end
  end

  function automatic bus_t mk(input logic [4:0] s, input logic re, input logic we,
                              input logic [7:0] d, input logic dn, input logic er,
                              input logic rdy);
    bus_t b;
    b.sel = s; b.re = re; b.we = we; b.d = d; b.done = dn; b.err = er; b.ready = rdy;
    return b;
  endfunction

  function automatic logic [4:0] oh(input logic [2:0] i);
    return 5'b00001 << i;
  endfunction

  // Expected bus cycles of one accepted request, from the register contents now.
  task automatic push_req(input logic [1:0] op, input logic [2:0] dst,
                          input logic [2:0] src, input logic [7:0] imm);
    logic uses_src;
    uses_src = (op == 2'b00) || (op == 2'b10);
    if (dst > 3'd4 || (uses_src && src > 3'd4)) begin
      q.push_back(mk(5'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
      q.push_back(mk(5'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
      return;
    end
    case (op)
      2'b00: begin
        q.push_back(mk(oh(src), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(oh(dst), 1'b0, 1'b1, m[src], 1'b0, 1'b0, 1'b0));
      end
      2'b01: q.push_back(mk(oh(dst), 1'b0, 1'b1, imm, 1'b0, 1'b0, 1'b0));
      2'b10: begin
        q.push_back(mk(oh(src), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(oh(dst), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(oh(dst), 1'b0, 1'b1, m[src], 1'b0, 1'b0, 1'b0));
        q.push_back(mk(oh(src), 1'b0, 1'b1, m[dst], 1'b0, 1'b0, 1'b0));
      end
      default: q.push_back(mk(oh(dst), 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    endcase
    q.push_back(mk(5'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
  endtask

  // Per-cycle compare; model registers follow each expected write as it retires.
  always @(negedge clk) begin
    bus_t exp_b, act_b;
    if (!rst) begin
      q.delete();
      if (stub_clr) for (int i = 0; i < 5; i++) m[i] = 8'h00;
    end else begin
      exp_b = (q.size() > 0) ? q.pop_front()
                             : mk(5'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      act_b = {sel_v, rf_re, rf_we, rf_d, done, err, req_ready};
      checks++;
      if (act_b !== exp_b) begin
        failures++;
        $display("FAIL bus_cycle t=%0t got sel=%b re=%b we=%b d=%h done=%b err=%b rdy=%b want sel=%b re=%b we=%b d=%h done=%b err=%b rdy=%b",
                 $time, act_b.sel, act_b.re, act_b.we, act_b.d, act_b.done, act_b.err, act_b.ready,
                 exp_b.sel, exp_b.re, exp_b.we, exp_b.d, exp_b.done, exp_b.err, exp_b.ready);
      end
      if (exp_b.we)
        for (int i = 0; i < 5; i++) if (exp_b.sel[i]) m[i] = exp_b.d;
      if (req_valid && q.size() == 0) push_req(req_op, req_dst, req_src, req_imm);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] dst,
                      input logic [2:0] src, input logic [7:0] imm);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_op = op; req_dst = dst; req_src = src; req_imm = imm; req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=busy want=ready op=%0d", op);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  function automatic logic [2:0] rnd_idx();
    return ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
  endfunction

  initial begin
    rst = 1'b0; stub_clr = 1'b1; req_valid = 1'b0;
    req_op = 2'b00; req_dst = 3'd0; req_src = 3'd0; req_imm = 8'h00;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {sel_v, rf_re, rf_we, rf_d, done, err}, 32'h0);
    #2 rst = 1'b1; stub_clr = 1'b0;
    @(negedge clk) chk("reset_ready", {31'b0, req_ready}, 32'h1);

    send(2'b01, 3'd1, 3'd0, 8'h5A);
    @(negedge clk) chk("ldi_write", {sel_v, rf_re, rf_we, rf_d}, {17'b0, 5'b00010, 1'b0, 1'b1, 8'h5A});
    @(negedge clk) chk("ldi_done", {done, rf_we}, 32'h2);
    chk("ldi_stub_b", stub[1], 32'h5A);

    send(2'b01, 3'd0, 3'd0, 8'h11);
    send(2'b00, 3'd4, 3'd0, 8'h00);
    @(negedge clk) chk("mov_read_a", {sel_v, rf_re, rf_we}, {25'b0, 5'b00001, 2'b10});
    @(negedge clk) chk("mov_write_f", {sel_v, rf_re, rf_we, rf_d}, {17'b0, 5'b10000, 2'b01, 8'h11});
    @(negedge clk) chk("mov_done", {31'b0, done}, 32'h1);

    send(2'b01, 3'd2, 3'd0, 8'h33);
    send(2'b01, 3'd3, 3'd0, 8'hC4);
    send(2'b10, 3'd3, 3'd2, 8'h00);
    @(negedge clk) chk("swp_read_c", {sel_v, rf_re, rf_we}, {25'b0, 5'b00100, 2'b10});
    @(negedge clk) chk("swp_read_d", {sel_v, rf_re, rf_we}, {25'b0, 5'b01000, 2'b10});
    @(negedge clk) chk("swp_write_d", {sel_v, rf_we, rf_d}, {18'b0, 5'b01000, 1'b1, 8'h33});
    @(negedge clk) chk("swp_write_c", {sel_v, rf_we, rf_d}, {18'b0, 5'b00100, 1'b1, 8'hC4});
    @(negedge clk) chk("swp_done", {31'b0, done}, 32'h1);
    chk("swp_stub_cd", {stub[2], stub[3]}, 32'hC433);

    send(2'b01, 3'd4, 3'd0, 8'h80);
    send(2'b00, 3'd0, 3'd4, 8'h00);
    repeat (3) @(negedge clk);
    chk("mov_from_f", stub[0], 32'h80);

    send(2'b00, 3'd6, 3'd0, 8'h00);
    @(negedge clk) chk("bad_idx_quiet", {sel_v, rf_re, rf_we, done, err}, 32'h0);
    @(posedge clk); #1;
    req_op = 2'b01; req_dst = 3'd0; req_imm = 8'h77; req_valid = 1'b1;
    @(negedge clk) chk("bad_idx_err", {err, done, req_ready}, 32'h5);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk) chk("after_err_accept", {sel_v, rf_we, rf_d}, {18'b0, 5'b00001, 1'b1, 8'h77});

    send(2'b10, 3'd3, 3'd2, 8'h00);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1 chk("async_reset", {sel_v, rf_re, rf_we, rf_d, done, err}, 32'h0);
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk) chk("post_reset_idle", {sel_v, rf_re, rf_we, done, req_ready}, 32'h1);
    @(negedge clk) chk("post_reset_no_done", {31'b0, done}, 32'h0);
    chk("abandoned_swp_cd", {stub[2], stub[3]}, 32'hC433);

    repeat (400) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
      req_dst   = rnd_idx();
      req_src   = rnd_idx();
      req_imm   = 8'($urandom);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) chk($sformatf("final_reg%0d", i), stub[i], m[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
